sample_framer: RTL and testbench
================================

// Module: sample_framer
// PURPOSE
//  Ping-pong input framer that feeds the DFT matrix stage (computeMatrix).
//  Accepts a stream of complex samples over a valid/ready handshake.
//  Collects N consecutive samples into one frame.
//  Presents each complete frame in parallel as x[N][1:0] ([0]=re, [1]=im) under frame_valid/frame_ready.
//  Two banks: one bank fills while the other is held stable for the DFT.
// PARAMETERS
//  N  16  samples per frame; power of 2, >= 2
//  W  16  bits per real/imag component, signed two's complement
// PORTS
//  clk          in   1          single clock; all state on rising edge
//  rst          in   1          asynchronous, active-high reset
//  flush        in   1          synchronous; discards partial and full frames
//  s_valid      in   1          input sample valid
//  s_ready      out  1          framer can accept a sample
//  s_re         in   W signed   sample real part
//  s_im         in   W signed   sample imaginary part
//  frame_valid  out  1          frame_x holds a complete frame
//  frame_ready  in   1          consumer takes the frame this cycle
//  frame_x      out  [W-1:0] signed x[N][1:0]   frame for the DFT stage
//  frame_seq    out  8          frame sequence number, +1 per accepted frame, wraps 255->0
// BEHAVIOUR
//  State:
//   - banks bank[2][N][2]
//   - full[1:0]
//   - wr_sel, rd_sel (1 b each)
//   - wr_idx ($clog2(N) b)
//   - frame_seq
//  Reset (async, rst=1): full=0, wr_sel=rd_sel=0, wr_idx=0, frame_seq=0, bank contents=0.
//   - Outputs during reset: s_ready=1, frame_valid=0, frame_x=all 0.
//  Combinational outputs from registers only:
//   - s_ready = !full[wr_sel]
//   - frame_valid = full[rd_sel]
//   - frame_x = bank[rd_sel]
//  Write side, on s_valid && s_ready:
//   - bank[wr_sel][addr] <= {s_im, s_re}, where addr = wr_idx (natural order).
//   - wr_idx increments.
//   - When wr_idx == N-1: wr_idx wraps to 0, full[wr_sel] <= 1, wr_sel toggles.
//  Read side, on frame_valid && frame_ready:
//   - full[rd_sel] <= 0, rd_sel toggles, frame_seq increments.
//  Latency:
//   - Last sample accepted at edge t -> frame_valid=1 in cycle after t.
//   - Frame consumed at edge t -> its bank writable (s_ready=1) in cycle after t.
//  Stability: bank[rd_sel] is never written while full.
//   - frame_x is constant from frame_valid rise until the handshake.
//  Simultaneous last-sample write and frame accept (different banks):
//   - Both take effect in the same edge; full[] updates are independent per bank.
//  Both banks full: s_ready=0; input stalls losslessly.
//   - s_re/s_im are ignored while s_valid && !s_ready.
//  Back-to-back frames: with frame_ready held at 1, s_valid held at 1 sustains 1 sample/cycle with no bubble.
//  flush=1 at an edge:
//   - full=0, wr_idx=0, wr_sel=rd_sel=0; frame_seq unchanged.
//   - Overrides any handshake in the same cycle; that sample and frame are dropped.
//  Mid-operation rst: identical to power-on reset; partial frames are lost.
//  No arithmetic on samples; widths pass through unchanged (W in, W out).
// CONFIGURATION
//  FRAMER_BITREV_EN defined:
//   - Write address = bit-reverse of wr_idx over $clog2(N) bits.
//   - Frame is stored in bit-reversed order, for a radix-2 FFT replacement.
//   - Handshake and timing are unchanged.
//  FRAMER_BITREV_EN undefined: natural order, frame_x[k] = k-th sample of the frame.
// TESTING
//  T1 reset: rst=1 mid-fill (5 samples in) -> s_ready=1, frame_valid=0, frame_x all 0.
//   - After release, the next 16 samples form frame 0, frame_seq=0.
//  T2 single frame: feed re=k, im=-k for k=0..15, frame_ready=0.
//   - frame_valid rises 1 cycle after the 16th accept.
//   - frame_x[k][0]=k, frame_x[k][1]=-k; stable for 20 idle cycles.
//  T3 backpressure: frame_ready=0, feed 40 samples.
//   - s_ready drops after the 32nd accept.
//   - Raise frame_ready 1 cycle -> s_ready=1 next cycle, frame_seq=1.
//   - Sample 33 is not lost.
//  T4 streaming: frame_ready=1, s_valid=1 for 160 cycles with re=cycle count.
//   - 10 frames; frame_seq 0..9; zero stall cycles; frame n holds 16n..16n+15.
//  T5 flush: 7 samples plus one full bank, then flush=1 with a concurrent handshake.
//   - Next cycle frame_valid=0, s_ready=1, frame_seq unchanged.
//   - Next frame starts at the next accepted sample.
//  T6 with FRAMER_BITREV_EN, N=16: feed re=k -> frame_x[bitrev4(k)][0]=k.
//   - frame_x[1][0]=8, frame_x[8][0]=1.

Source files
------------

// File: rtl/sample_framer.sv
// sample_framer: ping-pong framer that gathers N complex samples per frame for the DFT stage.
// Define FRAMER_BITREV_EN to store each frame in bit-reversed address order.
module sample_framer #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_re,
  input  logic signed [W-1:0] s_im,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic signed [W-1:0] frame_x [N][2],
  output logic [7:0]          frame_seq
);
  localparam int AW = $clog2(N);

  logic signed [W-1:0] bank_reg [2][N][2];
  logic [1:0]          full_reg;
  logic [1:0]          full_next;
  logic                wr_sel_reg;
  logic                rd_sel_reg;
  logic [AW-1:0]       wr_idx_reg;
  logic [AW-1:0]       waddr;
  logic [7:0]          seq_reg;
  logic                s_fire;
  logic                f_fire;
  logic                last_sample;

  assign s_ready     = !full_reg[wr_sel_reg];
  assign frame_valid = full_reg[rd_sel_reg];
  assign frame_seq   = seq_reg;

  // flush wins over both handshakes: neither the sample nor the frame is taken
  assign s_fire      = s_valid && s_ready && !flush;
  assign f_fire      = frame_valid && frame_ready && !flush;
  assign last_sample = (wr_idx_reg == AW'(N - 1));

  generate
`ifdef FRAMER_BITREV_EN
    for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
      assign waddr[gi] = wr_idx_reg[AW-1-gi];
    end
`else
    assign waddr = wr_idx_reg;
`endif
  endgenerate

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign frame_x[gi][0] = bank_reg[rd_sel_reg][gi][0];
    assign frame_x[gi][1] = bank_reg[rd_sel_reg][gi][1];
  end

  // The filling and draining banks always differ, so both updates can land together.
  always_comb begin
    full_next = full_reg;
    if (f_fire)
      full_next[rd_sel_reg] = 1'b0;
    if (s_fire && last_sample)
      full_next[wr_sel_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg   <= '0;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
      wr_idx_reg <= '0;
      seq_reg    <= '0;
    end else if (flush) begin
      full_reg   <= '0;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
      wr_idx_reg <= '0;
    end else begin
      full_reg <= full_next;
      if (s_fire) begin
        wr_idx_reg <= last_sample ? '0 : wr_idx_reg + 1'b1;
        if (last_sample)
          wr_sel_reg <= ~wr_sel_reg;
      end
      if (f_fire) begin
        rd_sel_reg <= ~rd_sel_reg;
        seq_reg    <= seq_reg + 8'd1;
      end
    end
  end

  // A full bank is never written, which keeps frame_x stable until it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_reg[b][k][0] <= '0;
          bank_reg[b][k][1] <= '0;
        end
      end
    end else if (s_fire) begin
      bank_reg[wr_sel_reg][waddr][0] <= s_re;
      bank_reg[wr_sel_reg][waddr][1] <= s_im;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: accepted samples are queued, frames are checked on handshake.
// Honours FRAMER_BITREV_EN when the design is built with it.
module tb_sample_framer;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int AW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_re;
  logic signed [W-1:0] s_im;
  logic                frame_valid;
  logic                frame_ready;
  logic signed [W-1:0] frame_x [N][2];
  logic [7:0]          frame_seq;

  typedef struct {
    int re;
    int im;
  } smp_t;

  smp_t       exp_q[$];
  logic [7:0] exp_seq;
  int         frames_seen;
  int         tests_run    = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  sample_framer #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_x    (frame_x),
    .frame_seq  (frame_seq)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position in frame_x where the k-th sample of a frame lands.
  function automatic int pos(input int k);
`ifdef FRAMER_BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++)
      if (k[b]) r |= (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic check_frame(input string tag);
    check({tag, "_qsize_ok"}, longint'(exp_q.size() >= N), 1);
    if (exp_q.size() >= N) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("%s_re%0d", tag, k), frame_x[pos(k)][0], exp_q[k].re);
        check($sformatf("%s_im%0d", tag, k), frame_x[pos(k)][1], exp_q[k].im);
      end
    end
  endtask

  // Records handshakes seen before the edge, then advances to 1 time unit past it.
  task automatic tick();
    if (flush) begin
      exp_q.delete();
    end else begin
      if (s_valid && s_ready)
        exp_q.push_back('{re: int'(s_re), im: int'(s_im)});
      if (frame_valid && frame_ready) begin
        check_frame("frame");
        check("frame_seq", frame_seq, exp_seq);
        $display("[TB] frame consumed seq=%0d", frame_seq);
        for (int k = 0; k < N && exp_q.size() > 0; k++)
          void'(exp_q.pop_front());
        exp_seq = exp_seq + 8'd1;
        frames_seen++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_n(input int n, input int base);
    int j      = 0;
    int budget = 0;
    while (j < n && budget < 200) begin
      s_valid = 1'b1;
      if (s_ready) begin
        s_re = W'(base + j);
        s_im = W'(-(base + j));
        j++;
      end else begin
        s_re = W'($urandom);
        s_im = W'($urandom);
      end
      tick();
      budget++;
    end
    s_valid = 1'b0;
    check("feed_accepts", j, n);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_frame_valid"}, frame_valid, 0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_x%0d_re", tag, k), frame_x[k][0], 0);
      check($sformatf("%s_x%0d_im", tag, k), frame_x[k][1], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    check({tag, "_seq"}, frame_seq, 0);
    $display("[TB] reset %s done", tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    flush       = 1'b0;
    s_valid     = 1'b0;
    frame_ready = 1'b0;
    s_re        = '0;
    s_im        = '0;
    exp_seq     = 8'd0;
    frames_seen = 0;
    do_reset("por");

    // T1: reset in the middle of a fill
    feed_n(5, 100);
    do_reset("t1");

    // T2: one frame, held while the consumer is idle
    feed_n(15, 0);
    check("t2_fv_before_last", frame_valid, 0);
    feed_n(1, 15);
    check("t2_fv_after_last", frame_valid, 1);
    check_frame("t2_held");
`ifdef FRAMER_BITREV_EN
    check("t6_x1", frame_x[1][0], 8);
    check("t6_x8", frame_x[8][0], 1);
`endif
    for (int c = 0; c < 20; c++) begin
      check("t2_fv_idle", frame_valid, 1);
      tick();
    end
    check_frame("t2_stable");
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t2_seq_after", frame_seq, 1);

    // T3: backpressure with both banks full
    do_reset("t3");
    feed_n(32, 0);
    check("t3_stall", s_ready, 0);
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1;
      s_re    = W'($urandom);
      s_im    = W'($urandom);
      check("t3_stall_hold", s_ready, 0);
      tick();
    end
    s_valid     = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t3_ready_back", s_ready, 1);
    check("t3_seq", frame_seq, 1);
    check("t3_fv_second", frame_valid, 1);
    feed_n(16, 32);
    frame_ready = 1'b1;
    tick();
    tick();
    frame_ready = 1'b0;
    check("t3_seq_end", frame_seq, 3);

    // T4: continuous streaming, one sample per cycle
    do_reset("t4");
    frames_seen = 0;
    frame_ready = 1'b1;
    for (int c = 0; c < 10 * N; c++) begin
      s_valid = 1'b1;
      s_re    = W'(c);
      s_im    = W'(-c);
      check("t4_no_stall", s_ready, 1);
      tick();
    end
    s_valid = 1'b0;
    tick();
    frame_ready = 1'b0;
    check("t4_frames", frames_seen, 10);
    check("t4_seq", frame_seq, 10);

    // T5: flush with a concurrent sample and frame handshake
    feed_n(16, 500);
    feed_n(7, 600);
    check("t5_fv_pre", frame_valid, 1);
    flush       = 1'b1;
    s_valid     = 1'b1;
    s_re        = W'(777);
    s_im        = W'(-777);
    frame_ready = 1'b1;
    tick();
    flush       = 1'b0;
    s_valid     = 1'b0;
    frame_ready = 1'b0;
    check("t5_fv_post", frame_valid, 0);
    check("t5_ready_post", s_ready, 1);
    check("t5_seq_post", frame_seq, 10);
    feed_n(16, 700);
    check("t5_fv_refill", frame_valid, 1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t5_seq_end", frame_seq, 11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
